// File: rtl/hls_dbg_pkg.sv
// Shared definitions for the HLS dataflow debug monitors.
// Holds the monitor state encoding, the index-width helper used to size
// first_idx, and the THRESH legality check used at elaboration.
package hls_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SUSPECT  = 2'd1,
        DEADLOCK = 2'd2
    } dbg_state_e;

    // Width of an index into an n-entry vector; never below 1 bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // THRESH must be reachable by the counter and need at least two
    // blocked cycles so that SUSPECT is always visited.
    function automatic bit thresh_legal(input int thresh, input int cnt_w);
        return (thresh >= 2) &&
               (longint'(thresh) <= ((longint'(1) << cnt_w) - longint'(1)));
    endfunction

endpackage

// File: rtl/hls_dbg_prio_enc.sv
// Lowest-set-bit encoder.
// Ports:
//   vec  in  W   input vector
//   idx  out IW  index of the lowest set bit of vec, 0 when vec is 0
module hls_dbg_prio_enc #(
    parameter int W  = 5,
    parameter int IW = 3
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the last hit, the lowest bit, wins.
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/hls_deadlock_monitor_gen.sv
// Deadlock monitor for one HLS dataflow region.
// Watches N_AXIS stream block signals and N_INST sub-instance block
// signals, filters them through a persistence counter and latches a sticky
// deadlock flag plus a snapshot of the blocked channels.
// Ports:
//   clock, reset     clock and synchronous active-high reset
//   axis_block_sigs  per-channel stream block
//   inst_block_sigs  per-sub-instance block
//   inst_idle_sigs   per-sub-instance idle
//   chan_en          enable mask over {inst, axis}, axis in the LSBs
//   clear            pulse clearing the sticky state
//   block            registered, unfiltered OR of the masked blocks
//   deadlock         sticky deadlock flag
//   culprit          masked block vector captured at declaration
//   first_idx        lowest set index of culprit
//   stall_cycles     consecutive blocked-cycle count, saturating
//
// state    | meaning
// IDLE     | no blocked condition seen, counter at 0
// SUSPECT  | blocked for fewer than THRESH consecutive cycles
// DEADLOCK | THRESH consecutive blocked cycles seen; held until clear/reset
module hls_deadlock_monitor_gen
    import hls_dbg_pkg::*;
#(
    parameter int N_AXIS = 4,
    parameter int N_INST = 1,
    parameter int N_IDLE = 3,
    parameter int THRESH = 1024,
    parameter int CNT_W  = 16
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [N_AXIS-1:0]                             axis_block_sigs,
    input  logic [N_INST-1:0]                             inst_block_sigs,
    input  logic [N_IDLE-1:0]                             inst_idle_sigs,
    input  logic [N_AXIS+N_INST-1:0]                      chan_en,
    input  logic                                          clear,
    output logic                                          block,
    output logic                                          deadlock,
    output logic [N_AXIS+N_INST-1:0]                      culprit,
    output logic [idx_width(N_AXIS+N_INST)-1:0]           first_idx,
    output logic [CNT_W-1:0]                              stall_cycles
);

    localparam int N_CH  = N_AXIS + N_INST;
    localparam int IDX_W = idx_width(N_CH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (!thresh_legal(THRESH, CNT_W)) begin : g_bad_thresh
        $fatal(1, "hls_deadlock_monitor_gen: THRESH outside 2 .. 2^CNT_W-1");
    end

    logic [N_CH-1:0]  sig;
    logic             all_idle;
    logic             cond;
    dbg_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [N_CH-1:0]  culprit_q, culprit_nxt;
    logic             block_q;

    assign sig      = {inst_block_sigs, axis_block_sigs} & chan_en;
    assign all_idle = &inst_idle_sigs;
    // A region whose sub-instances are all idle has finished, not stalled.
    assign cond     = (|sig) & ~all_idle;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            culprit_q <= '0;
            block_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            culprit_q <= culprit_nxt;
            block_q   <= |sig;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        culprit_nxt = culprit_q;
        if (clear) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            culprit_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cond) begin
                        state_nxt = SUSPECT;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                SUSPECT: begin
                    if (cond) begin
                        cnt_nxt = cnt + CNT_ONE;
                        if (cnt == CNT_LAST) begin
                            state_nxt   = DEADLOCK;
                            culprit_nxt = sig;
                        end
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                DEADLOCK: begin
                    if (cond && (cnt != '1)) cnt_nxt = cnt + CNT_ONE;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    hls_dbg_prio_enc #(
        .W  (N_CH),
        .IW (IDX_W)
    ) u_prio_enc (
        .vec (culprit_q),
        .idx (first_idx)
    );

    assign block        = block_q;
    assign deadlock     = (state == DEADLOCK);
    assign culprit      = culprit_q;
    assign stall_cycles = cnt;

endmodule

// File: tb/tb_hls_deadlock_monitor_gen.sv
module tb_hls_deadlock_monitor_gen;

    localparam int THRESH = 8;
    localparam int MAX_L  = 65535;
    localparam int MAX_S  = 15;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] axis_block_sigs;
    logic [0:0] inst_block_sigs;
    logic [2:0] inst_idle_sigs;
    logic [4:0] chan_en;
    logic       clear;

    logic       block_l, deadlock_l, block_s, deadlock_s;
    logic [4:0] culprit_l, culprit_s;
    logic [2:0] first_idx_l, first_idx_s;
    logic [15:0] stall_l;
    logic [3:0]  stall_s;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: length of the current blocked run, sticky flag, snapshot.
    int       m_run;
    bit       m_dl;
    bit [4:0] m_cul;
    bit       m_blk;

    always #5 clock = ~clock;

    hls_deadlock_monitor_gen #(
        .N_AXIS(4), .N_INST(1), .N_IDLE(3), .THRESH(THRESH), .CNT_W(16)
    ) dut (
        .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
        .inst_block_sigs(inst_block_sigs), .inst_idle_sigs(inst_idle_sigs),
        .chan_en(chan_en), .clear(clear), .block(block_l), .deadlock(deadlock_l),
        .culprit(culprit_l), .first_idx(first_idx_l), .stall_cycles(stall_l)
    );

    hls_deadlock_monitor_gen #(
        .N_AXIS(4), .N_INST(1), .N_IDLE(3), .THRESH(THRESH), .CNT_W(4)
    ) dut_s (
        .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
        .inst_block_sigs(inst_block_sigs), .inst_idle_sigs(inst_idle_sigs),
        .chan_en(chan_en), .clear(clear), .block(block_s), .deadlock(deadlock_s),
        .culprit(culprit_s), .first_idx(first_idx_s), .stall_cycles(stall_s)
    );

    typedef struct {
        logic [3:0] axis;
        logic       inst;
        logic [2:0] idle;
        logic [4:0] en;
        logic       clr;
        logic       rst;
        int         cyc;
        logic       e_blk;
        logic       e_dl;
        int         e_stall;
        logic [4:0] e_cul;
        logic [2:0] e_fidx;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic [3:0] axis, logic inst, logic [2:0] idle,
                                logic [4:0] en, logic clr, logic rst, int cyc,
                                logic e_blk, logic e_dl, int e_stall,
                                logic [4:0] e_cul, logic [2:0] e_fidx);
        vec_t v;
        v.axis = axis; v.inst = inst; v.idle = idle; v.en = en; v.clr = clr;
        v.rst = rst; v.cyc = cyc; v.e_blk = e_blk; v.e_dl = e_dl;
        v.e_stall = e_stall; v.e_cul = e_cul; v.e_fidx = e_fidx;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int lowest_bit(bit [4:0] v);
        for (int i = 0; i < 5; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic drive(logic [3:0] axis, logic inst, logic [2:0] idle,
                         logic [4:0] en, logic clr, logic rst);
        axis_block_sigs = axis;
        inst_block_sigs = inst;
        inst_idle_sigs  = idle;
        chan_en         = en;
        clear           = clr;
        reset           = rst;
    endtask

    // One clock: advance the model on the sampled inputs, then compare both DUTs.
    task automatic step();
        bit [4:0] s;
        bit c;
        @(posedge clock);
        s = {inst_block_sigs, axis_block_sigs} & chan_en;
        c = (s != 0) && (inst_idle_sigs != 3'b111);
        if (reset) begin
            m_run = 0; m_dl = 0; m_cul = 0; m_blk = 0;
        end else begin
            m_blk = (s != 0);
            if (clear) begin
                m_run = 0; m_dl = 0; m_cul = 0;
            end else if (!m_dl) begin
                if (c) begin
                    m_run++;
                    if (m_run == THRESH) begin
                        m_dl  = 1;
                        m_cul = s;
                    end
                end else begin
                    m_run = 0;
                end
            end else if (c) begin
                m_run++;
            end
        end
        #1;
        check("model_block",    32'(block_l),     32'(m_blk));
        check("model_deadlock", 32'(deadlock_l),  32'(m_dl));
        check("model_culprit",  32'(culprit_l),   32'(m_cul));
        check("model_first_idx",32'(first_idx_l), 32'(lowest_bit(m_cul)));
        check("model_stall",    32'(stall_l),     32'(sat(m_run, MAX_L)));
        check("model_block_s",    32'(block_s),     32'(m_blk));
        check("model_deadlock_s", 32'(deadlock_s),  32'(m_dl));
        check("model_culprit_s",  32'(culprit_s),   32'(m_cul));
        check("model_first_idx_s",32'(first_idx_s), 32'(lowest_bit(m_cul)));
        check("model_stall_s",    32'(stall_s),     32'(sat(m_run, MAX_S)));
    endtask

    initial begin
        m_run = 0; m_dl = 0; m_cul = 0; m_blk = 0;
        drive(4'h0, 1'b0, 3'b000, 5'h1F, 1'b0, 1'b1);

        //   axis  inst idle    en   clr  rst cyc | blk dl stall cul   fidx
        add(4'h0, 0, 3'b000, 5'h1F, 0, 1,  2,   0, 0,  0, 5'h00, 0);
        add(4'h4, 0, 3'b000, 5'h1F, 0, 0,  1,   1, 0,  1, 5'h00, 0);
        add(4'h4, 0, 3'b000, 5'h1F, 0, 0,  6,   1, 0,  7, 5'h00, 0);
        add(4'h4, 0, 3'b000, 5'h1F, 0, 0,  1,   1, 1,  8, 5'h04, 2);
        add(4'h4, 0, 3'b000, 5'h1F, 0, 0,  4,   1, 1, 12, 5'h04, 2);
        add(4'h0, 0, 3'b000, 5'h1F, 0, 0,  1,   0, 1, 12, 5'h04, 2);
        add(4'h4, 0, 3'b000, 5'h1F, 1, 0,  1,   1, 0,  0, 5'h00, 0);
        add(4'h4, 0, 3'b000, 5'h1F, 0, 0,  5,   1, 0,  5, 5'h00, 0);
        add(4'h0, 0, 3'b000, 5'h1F, 0, 0,  1,   0, 0,  0, 5'h00, 0);
        add(4'h4, 0, 3'b000, 5'h1F, 0, 0,  7,   1, 0,  7, 5'h00, 0);
        add(4'h4, 0, 3'b000, 5'h1F, 0, 0,  1,   1, 1,  8, 5'h04, 2);
        add(4'h4, 0, 3'b111, 5'h1F, 1, 0,  1,   1, 0,  0, 5'h00, 0);
        add(4'hF, 1, 3'b111, 5'h1F, 0, 0, 20,   1, 0,  0, 5'h00, 0);
        add(4'h1, 0, 3'b000, 5'h1E, 0, 0, 10,   0, 0,  0, 5'h00, 0);
        add(4'h1, 1, 3'b000, 5'h1E, 0, 0,  8,   1, 1,  8, 5'h10, 4);
        add(4'h1, 1, 3'b000, 5'h01, 0, 0,  2,   1, 1, 10, 5'h10, 4);
        add(4'h4, 0, 3'b000, 5'h1F, 1, 0,  1,   1, 0,  0, 5'h00, 0);
        add(4'h4, 0, 3'b000, 5'h1F, 0, 0,  7,   1, 0,  7, 5'h00, 0);
        add(4'h4, 0, 3'b000, 5'h1F, 0, 0,  1,   1, 1,  8, 5'h04, 2);
        add(4'h4, 0, 3'b000, 5'h1F, 1, 0,  1,   1, 0,  0, 5'h00, 0);
        add(4'h4, 0, 3'b000, 5'h1F, 0, 0,  3,   1, 0,  3, 5'h00, 0);
        add(4'h4, 0, 3'b000, 5'h1F, 0, 1,  1,   0, 0,  0, 5'h00, 0);
        add(4'h4, 0, 3'b000, 5'h1F, 0, 0, 40,   1, 1, 40, 5'h04, 2);

        foreach (vecs[k]) begin
            drive(vecs[k].axis, vecs[k].inst, vecs[k].idle, vecs[k].en,
                  vecs[k].clr, vecs[k].rst);
            repeat (vecs[k].cyc) step();
            check($sformatf("vec%0d_block", k),     32'(block_l),     32'(vecs[k].e_blk));
            check($sformatf("vec%0d_deadlock", k),  32'(deadlock_l),  32'(vecs[k].e_dl));
            check($sformatf("vec%0d_stall", k),     32'(stall_l),     32'(vecs[k].e_stall));
            check($sformatf("vec%0d_culprit", k),   32'(culprit_l),   32'(vecs[k].e_cul));
            check($sformatf("vec%0d_first_idx", k), 32'(first_idx_l), 32'(vecs[k].e_fidx));
            check($sformatf("vec%0d_stall_s", k),   32'(stall_s),     32'(sat(vecs[k].e_stall, MAX_S)));
            check($sformatf("vec%0d_deadlock_s", k),32'(deadlock_s),  32'(vecs[k].e_dl));
        end

        // Gap exactly in the last cycle before declaration restarts the run.
        drive(4'h0, 0, 3'b000, 5'h1F, 0, 1);
        step();
        drive(4'h2, 0, 3'b000, 5'h1F, 0, 0);
        repeat (7) step();
        check("edge_pre_dl", 32'(deadlock_l), 32'd0);
        check("edge_pre_stall", 32'(stall_l), 32'd7);
        drive(4'h0, 0, 3'b000, 5'h1F, 0, 0);
        step();
        check("edge_gap_stall", 32'(stall_l), 32'd0);
        check("edge_gap_dl", 32'(deadlock_l), 32'd0);
        drive(4'h2, 0, 3'b000, 5'h1F, 0, 0);
        repeat (7) step();
        check("edge_re_dl", 32'(deadlock_l), 32'd0);
        step();
        check("edge_re_dl_set", 32'(deadlock_l), 32'd1);
        check("edge_re_culprit", 32'(culprit_l), 32'h02);
        check("edge_re_first_idx", 32'(first_idx_l), 32'd1);

        // Randomised run with slowly changing inputs so long blocked runs occur.
        drive(4'h0, 0, 3'b000, 5'h1F, 0, 1);
        step();
        reset = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 15) == 0) axis_block_sigs = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) inst_block_sigs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) inst_idle_sigs  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 63) == 0) chan_en         = 5'($urandom_range(0, 31));
            clear = ($urandom_range(0, 99) == 0);
            reset = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hls_deadlock_monitor_gen.md
# hls_deadlock_monitor_gen

Parametrised second-generation deadlock monitor for HLS dataflow regions. It generalises the fixed per-instance monitor to N AXI-Stream channels and M sub-instance block signals, and adds a persistence filter, a sticky deadlock flag, a culprit snapshot and a clear. One instance sits beside each dataflow region and feeds the debug CSR block and the top-level deadlock interrupt.

## Interface
Parameters:
- N_AXIS, 4, number of AXI-Stream block signals
- N_INST, 1, number of sub-instance block signals
- N_IDLE, 3, number of sub-instance idle signals
- THRESH, 1024, consecutive blocked cycles that declare deadlock; legal range 2 .. 2^CNT_W-1
- CNT_W, 16, stall counter width

Ports (reset: synchronous, active-high; clock: clock):
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- axis_block_sigs  in  N_AXIS  per-channel stream block
- inst_block_sigs  in  N_INST  per-sub-instance block
- inst_idle_sigs  in  N_IDLE  per-sub-instance idle
- chan_en  in  N_AXIS+N_INST  enable mask over {inst, axis}; axis occupies the LSBs
- clear  in  1  single-cycle pulse that clears sticky state
- block  out  1  registered instantaneous block; matches the previous-generation output
- deadlock  out  1  sticky deadlock flag
- culprit  out  N_AXIS+N_INST  masked block vector captured at declaration
- first_idx  out  clog2(N_AXIS+N_INST)  lowest set index of culprit
- stall_cycles  out  CNT_W  current consecutive blocked-cycle count, saturating

## Operation
- sig = {inst_block_sigs, axis_block_sigs} & chan_en.
- all_idle = &inst_idle_sigs.
- cond = (|sig) & ~all_idle. When every sub-instance is idle, the region is finished, not deadlocked.
- block <= |sig every cycle. The block output is unfiltered and does not depend on idle.
- State machine: IDLE, SUSPECT, DEADLOCK.
  - IDLE, cond=1: go to SUSPECT, cnt <= 1.
  - SUSPECT, cond=1: cnt <= cnt+1. If cnt == THRESH-1: go to DEADLOCK, culprit <= sig.
  - SUSPECT, cond=0: go to IDLE, cnt <= 0.
  - DEADLOCK: sticky regardless of cond. cnt keeps incrementing while cond=1 and saturates at all-ones. cnt holds while cond=0.
- clear (any state): go to IDLE, cnt <= 0, culprit <= 0. Clear has priority over cond in the same cycle; counting restarts from the next cycle.
- deadlock = (state == DEADLOCK). stall_cycles = cnt.
- first_idx is combinational from culprit. It is 0 when culprit is 0.

## Timing
- Reset values: block=0, deadlock=0, culprit=0, first_idx=0, stall_cycles=0, state IDLE.
- block has 1-cycle latency from its inputs.
- If cond is high for cycles 0..THRESH-1, deadlock rises at cycle THRESH. A single low cycle before that point restarts the count.
- culprit holds the sig value sampled in cycle THRESH-1.
- Reset mid-operation returns all state to the reset values on the next edge, including from DEADLOCK.
- Changing chan_en while in DEADLOCK does not alter culprit.

## Structure
- Shared package hls_dbg_pkg holds:
  - the state enum (IDLE=2'd0, SUSPECT=2'd1, DEADLOCK=2'd2)
  - the clog2-based index-width function
  - the THRESH legality check, which is an elaboration-time assertion
- One sub-module, hls_dbg_prio_enc. It is a parametrised lowest-set-bit encoder that produces first_idx.

## Test plan
- After reset, drive axis_block_sigs=4'b0100 with chan_en all-ones, THRESH=8. block=1 one cycle later. deadlock=1 exactly at cycle 8. culprit=5'b00100, first_idx=2.
- Hold the block for 5 cycles, drop it for 1 cycle, then hold it again. deadlock is first high 8 cycles after the re-assert. stall_cycles returns to 0 on the gap.
- Drive inst_idle_sigs=3'b111 with blocks asserted. block=1, deadlock stays 0 indefinitely, stall_cycles=0.
- With chan_en=5'b11110, drive axis bit 0 only. block=0 and deadlock=0. With inst_block_sigs=1, culprit=5'b10000 and first_idx=4.
- In DEADLOCK, pulse clear while the block is held. deadlock=0 the next cycle and re-declares 8 cycles later. Assert reset mid-SUSPECT: all outputs are 0 the next cycle.
- CNT_W=4, THRESH=8, block held 40 cycles. stall_cycles saturates at 15 and deadlock stays 1.
